// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores onto a req/gnt/rvalid data bus.
// Optional MEM_MISALIGN_CHK_EN traps misaligned requests instead of aligning them down.
`ifndef XLEN
`define XLEN 64
`endif

module dmem_access_ctrl #(
  parameter int XLEN = `XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic              flushmem_i,
  output logic              memstall_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [XLEN-1:0]   bus_addr_o,
  output logic [XLEN-1:0]   bus_wdata_o,
  output logic [XLEN/8-1:0] bus_strb_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [XLEN-1:0]   bus_rdata_i,
  output logic              misalign_o
);
  // state | meaning
  // IDLE  | nothing outstanding, accepts a new request
  // REQ   | bus request held, waiting for grant
  // WAIT  | granted, waiting for response
  // DONE  | single completion cycle, rdata_o valid
  // DRAIN | flushed after grant, swallowing the response
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IW   = $clog2(XLEN);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d, we_q, we_d;

  logic            req_valid, misalign;
  logic [XLEN-1:0] cur_mask, eff_addr, rd_shift, rd_ext;
  logic [OFFW-1:0] off;
  logic [NB-1:0]   strb_base;
  logic [IW-1:0]   sign_idx;
  int              nbits;

  // Reset gates the request so every output reads 0 while rst_n is low.
  assign req_valid = rst_n & (mem_re_i | mem_we_i) & ~flushmem_i;

`ifdef MEM_MISALIGN_CHK_EN
  logic [XLEN-1:0] in_mask;
  assign in_mask  = (XLEN'(1) << mem_size_i) - XLEN'(1);
  assign misalign = |(mem_addr_i & in_mask);
`else
  assign misalign = 1'b0;
`endif

  // With the check enabled the low bits are already zero, so the mask is a no-op.
  assign cur_mask = (XLEN'(1) << size_q) - XLEN'(1);
  assign eff_addr = addr_q & ~cur_mask;
  assign off      = eff_addr[OFFW-1:0];
  assign rd_shift = bus_rdata_i >> {off, 3'b000};

  always_comb begin
    strb_base = '0;
    for (int i = 0; i < NB; i++) strb_base[i] = (i < (1 << size_q));
  end

  always_comb begin
    rd_ext = '0;
    nbits  = 8 << size_q;
    if (nbits > XLEN) nbits = XLEN;
    sign_idx = IW'(nbits - 1);
    for (int i = 0; i < XLEN; i++)
      rd_ext[i] = (i < nbits) ? rd_shift[i] : (~uns_q & rd_shift[sign_idx]);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    uns_d      = uns_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    memstall_o = 1'b0;
    done_o     = 1'b0;
    misalign_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (misalign) begin
            misalign_o = 1'b1;
          end else begin
            memstall_o = 1'b1;
            state_d    = S_REQ;
            addr_d     = mem_addr_i;
            wdata_d    = mem_wdata_i;
            size_d     = mem_size_i;
            uns_d      = mem_unsigned_i;
            we_d       = mem_we_i;
          end
        end
      end
      S_REQ: begin
        memstall_o = 1'b1;
        if (bus_gnt_i)       state_d = flushmem_i ? S_DRAIN : S_WAIT;
        else if (flushmem_i) state_d = S_IDLE;
      end
      S_WAIT: begin
        memstall_o = 1'b1;
        if (bus_rvalid_i) begin
          if (flushmem_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            rdata_d = we_q ? '0 : rd_ext;
          end
        end else if (flushmem_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        memstall_o = mem_re_i | mem_we_i;
        if (bus_rvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
    end
  end

  assign bus_req_o   = (state_q == S_REQ);
  assign bus_we_o    = bus_req_o & we_q;
  assign bus_addr_o  = bus_req_o ? eff_addr : '0;
  assign bus_wdata_o = bus_req_o ? (wdata_q << {off, 3'b000}) : '0;
  assign bus_strb_o  = bus_req_o ? (strb_base << off) : '0;
  assign rdata_o     = (state_q == S_DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl (XLEN=64).
module tb_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_re_i, mem_we_i, mem_unsigned_i, flushmem_i;
  logic [63:0] mem_addr_i, mem_wdata_i;
  logic [1:0]  mem_size_i;
  logic        memstall_o, done_o, bus_req_o, bus_we_o, misalign_o;
  logic [63:0] rdata_o, bus_addr_o, bus_wdata_o;
  logic [7:0]  bus_strb_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [63:0] bus_rdata_i;

  int errs   = 0;
  int checks = 0;
  int ms_cnt;

  dmem_access_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .flushmem_i(flushmem_i), .memstall_o(memstall_o), .done_o(done_o), .rdata_o(rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_strb_o(bus_strb_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".memstall"}, 64'(memstall_o), 64'd0);
    chk({tag, ".done"},     64'(done_o),     64'd0);
    chk({tag, ".bus_req"},  64'(bus_req_o),  64'd0);
    chk({tag, ".bus_we"},   64'(bus_we_o),   64'd0);
    chk({tag, ".bus_addr"}, bus_addr_o,      64'd0);
    chk({tag, ".bus_wdata"},bus_wdata_o,     64'd0);
    chk({tag, ".bus_strb"}, 64'(bus_strb_o), 64'd0);
    chk({tag, ".rdata"},    rdata_o,         64'd0);
    chk({tag, ".misalign"}, 64'(misalign_o), 64'd0);
  endtask

  task automatic set_req(input logic re, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [1:0] size, input logic uns);
    mem_re_i = re; mem_we_i = we; mem_addr_i = addr;
    mem_wdata_i = wdata; mem_size_i = size; mem_unsigned_i = uns;
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
    flushmem_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    next_cyc();

    // Load word, zero-wait bus
    set_req(1'b1, 1'b0, 64'h1004, 64'd0, 2'd2, 1'b0);
    @(negedge clk);
    chk("lw.c1.memstall", 64'(memstall_o), 64'd1);
    chk("lw.c1.bus_req", 64'(bus_req_o), 64'd0);
    next_cyc();
    bus_gnt_i = 1'b1;
    @(negedge clk);
    chk("lw.c2.bus_req", 64'(bus_req_o), 64'd1);
    chk("lw.c2.bus_addr", bus_addr_o, 64'h1004);
    chk("lw.c2.strb", 64'(bus_strb_o), 64'hF0);
    chk("lw.c2.we", 64'(bus_we_o), 64'd0);
    chk("lw.c2.memstall", 64'(memstall_o), 64'd1);
    next_cyc();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 64'h80000000_00000000;
    @(negedge clk);
    chk("lw.c3.memstall", 64'(memstall_o), 64'd1);
    chk("lw.c3.done", 64'(done_o), 64'd0);
    next_cyc();
    bus_rvalid_i = 1'b0; mem_re_i = 1'b0;
    @(negedge clk);
    chk("lw.c4.done", 64'(done_o), 64'd1);
    chk("lw.c4.memstall", 64'(memstall_o), 64'd0);
    chk("lw.c4.rdata", rdata_o, 64'hFFFFFFFF_80000000);
    next_cyc();
    @(negedge clk);
    chk("lw.c5.done", 64'(done_o), 64'd0);
    chk("lw.c5.bus_req", 64'(bus_req_o), 64'd0);
    next_cyc();

    // Store byte (re and we both high), grant on 5th REQ cycle with a same-cycle rvalid
    set_req(1'b1, 1'b1, 64'h2003, 64'hAB, 2'd0, 1'b0);
    ms_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      bus_gnt_i    = (k == 6);
      bus_rvalid_i = (k == 6) || (k == 7);
      if (k == 8) begin mem_re_i = 1'b0; mem_we_i = 1'b0; end
      @(negedge clk);
      if (memstall_o) ms_cnt++;
      if (k >= 2 && k <= 6) begin
        chk($sformatf("sb.c%0d.bus_req", k), 64'(bus_req_o), 64'd1);
        chk($sformatf("sb.c%0d.bus_we", k), 64'(bus_we_o), 64'd1);
        chk($sformatf("sb.c%0d.bus_addr", k), bus_addr_o, 64'h2003);
        chk($sformatf("sb.c%0d.wdata", k), bus_wdata_o, 64'h00000000_AB000000);
        chk($sformatf("sb.c%0d.strb", k), 64'(bus_strb_o), 64'h08);
      end
      if (k == 7) chk("sb.c7.done", 64'(done_o), 64'd0);
      if (k == 8) begin
        chk("sb.c8.done", 64'(done_o), 64'd1);
        chk("sb.c8.rdata", rdata_o, 64'd0);
      end
      next_cyc();
    end
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    chk("sb.memstall_cycles", 64'(ms_cnt), 64'd7);

    // Unsigned byte load at offset 5
    set_req(1'b1, 1'b0, 64'h5, 64'd0, 2'd0, 1'b1);
    next_cyc();
    bus_gnt_i = 1'b1;
    @(negedge clk);
    chk("lbu.strb", 64'(bus_strb_o), 64'h20);
    next_cyc();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 64'h0000F000_00000000;
    next_cyc();
    bus_rvalid_i = 1'b0; mem_re_i = 1'b0;
    @(negedge clk);
    chk("lbu.done", 64'(done_o), 64'd1);
    chk("lbu.rdata", rdata_o, 64'hF0);
    next_cyc();

    // Flush in WAIT -> DRAIN
    set_req(1'b1, 1'b0, 64'h10, 64'd0, 2'd3, 1'b1);
    next_cyc();
    bus_gnt_i = 1'b1;
    next_cyc();
    bus_gnt_i = 1'b0; flushmem_i = 1'b1; mem_re_i = 1'b0;
    next_cyc();
    flushmem_i = 1'b0; mem_re_i = 1'b1;
    @(negedge clk);
    chk("drain.memstall_req", 64'(memstall_o), 64'd1);
    chk("drain.done_a", 64'(done_o), 64'd0);
    next_cyc();
    mem_re_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    chk("drain.memstall_idle", 64'(memstall_o), 64'd0);
    chk("drain.done_b", 64'(done_o), 64'd0);
    next_cyc();
    bus_rvalid_i = 1'b0; mem_re_i = 1'b1; flushmem_i = 1'b1;
    @(negedge clk);
    chk("drain.back_idle.memstall", 64'(memstall_o), 64'd0);
    chk("drain.back_idle.done", 64'(done_o), 64'd0);
    chk("drain.back_idle.rdata", rdata_o, 64'd0);
    next_cyc();
    mem_re_i = 1'b0; flushmem_i = 1'b0;

    // Flush in REQ before grant
    set_req(1'b1, 1'b0, 64'h40, 64'd0, 2'd2, 1'b0);
    next_cyc();
    flushmem_i = 1'b1; mem_re_i = 1'b0;
    @(negedge clk);
    chk("reqflush.c2.bus_req", 64'(bus_req_o), 64'd1);
    next_cyc();
    flushmem_i = 1'b0;
    @(negedge clk);
    chk("reqflush.c3.bus_req", 64'(bus_req_o), 64'd0);
    chk("reqflush.c3.memstall", 64'(memstall_o), 64'd0);
    next_cyc();
    @(negedge clk);
    chk("reqflush.c4.done", 64'(done_o), 64'd0);
    next_cyc();

    // Misaligned half load
    set_req(1'b1, 1'b0, 64'h3001, 64'd0, 2'd1, 1'b0);
`ifdef MEM_MISALIGN_CHK_EN
    @(negedge clk);
    chk("mis.misalign", 64'(misalign_o), 64'd1);
    chk("mis.memstall", 64'(memstall_o), 64'd0);
    chk("mis.bus_req", 64'(bus_req_o), 64'd0);
    next_cyc();
    mem_re_i = 1'b0;
    @(negedge clk);
    chk("mis.misalign_after", 64'(misalign_o), 64'd0);
    chk("mis.bus_req_after", 64'(bus_req_o), 64'd0);
    next_cyc();
`else
    @(negedge clk);
    chk("mis.misalign", 64'(misalign_o), 64'd0);
    next_cyc();
    bus_gnt_i = 1'b1;
    @(negedge clk);
    chk("mis.bus_addr", bus_addr_o, 64'h3000);
    chk("mis.strb", 64'(bus_strb_o), 64'h03);
    next_cyc();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 64'h0000_0000_0000_8765;
    next_cyc();
    bus_rvalid_i = 1'b0; mem_re_i = 1'b0;
    @(negedge clk);
    chk("mis.done", 64'(done_o), 64'd1);
    chk("mis.rdata", rdata_o, 64'hFFFFFFFF_FFFF8765);
    next_cyc();
`endif

    // Reset during WAIT with the request still held
    set_req(1'b1, 1'b0, 64'h8, 64'd0, 2'd2, 1'b0);
    next_cyc();
    bus_gnt_i = 1'b1;
    next_cyc();
    bus_gnt_i = 1'b0;
    @(negedge clk);
    chk("rstwait.memstall_before", 64'(memstall_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rstwait");
    next_cyc();
    mem_re_i = 1'b0;
    rst_n = 1'b1;
    next_cyc();

    // Dword load after reset, unsigned flag ignored
    set_req(1'b1, 1'b0, 64'h18, 64'd0, 2'd3, 1'b1);
    next_cyc();
    bus_gnt_i = 1'b1;
    @(negedge clk);
    chk("ld.bus_addr", bus_addr_o, 64'h18);
    chk("ld.strb", 64'(bus_strb_o), 64'hFF);
    next_cyc();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 64'h80000000_00000001;
    next_cyc();
    bus_rvalid_i = 1'b0; mem_re_i = 1'b0;
    @(negedge clk);
    chk("ld.done", 64'(done_o), 64'd1);
    chk("ld.rdata", rdata_o, 64'h80000000_00000001);
    next_cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
